etapa_busqueda_pc: RTL and testbench



---
 rtl/riscv_pkg.sv | 20 ++
 rtl/buffer_salto_instr.sv | 44 ++++
 rtl/etapa_busqueda_pc.sv | 144 ++++++++++++++
 tb/tb_etapa_busqueda_pc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch front end: NOP encoding, fetch FSM
// state encoding and default reset/trap vectors.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;

   typedef enum logic [1:0] {
      ARRANQUE = 2'd0,
      PEDIR    = 2'd1,
      ESPERA   = 2'd2,
      DESCARTE = 2'd3
   } estado_e;

   function automatic logic [31:0] alinear(input logic [31:0] dir);
      return {dir[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/buffer_salto_instr.sv
// One-entry skid buffer holding a fetched word and its address while decode
// is stalled; flush discards the entry on a redirect.
module buffer_salto_instr
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        unload_i,
   input  logic        flush_i,
   input  logic [31:0] data_i,
   input  logic [31:0] pc_i,
   output logic [31:0] data_o,
   output logic [31:0] pc_o,
   output logic        full_o
);

   logic        full_q;
   logic [31:0] data_q;
   logic [31:0] pc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
      end else if (unload_i) begin
         full_q <= 1'b0;
      end

      if (rst_i) begin
         data_q <= NOP_INSTR;
         pc_q   <= '0;
      end else if (load_i) begin
         data_q <= data_i;
         pc_q   <= pc_i;
      end
   end

   assign data_o = data_q;
   assign pc_o   = pc_q;
   assign full_o = full_q;

endmodule

// File: rtl/etapa_busqueda_pc.sv
// PC register and instruction-fetch front end with req/ack memory handshake,
// valid/stall decode handshake and skid buffer. Optional macro: PC_ALIGN_CHECK_EN.
module etapa_busqueda_pc
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
)(
   input  logic        CLK,
   input  logic        RST,
   output logic [31:0] PC,
   input  logic [31:0] PC4,
   input  logic        SALTO,
   input  logic [31:0] DIR_SALTO,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_DATA,
   output logic [31:0] INSTR,
   output logic [31:0] INSTR_PC,
   output logic        INSTR_VALID,
   input  logic        STALL,
   output logic        ERR_ALIGN
);

   estado_e     estado_q;
   logic [31:0] pc_q, addr_q, instr_q, ipc_q;
   logic        req_q, valid_q, err_q;

   logic        skid_full;
   logic [31:0] skid_data, skid_pc;

   logic [31:0] tgt_d;
   logic        mis_d;
   logic        acepta, libre, skid_load, skid_unload;

`ifdef PC_ALIGN_CHECK_EN
   assign mis_d = |DIR_SALTO[1:0];
   assign tgt_d = mis_d ? TRAP_PC : DIR_SALTO;
`else
   logic unused_trap;
   assign mis_d       = 1'b0;
   assign tgt_d       = alinear(DIR_SALTO);
   assign unused_trap = ^{TRAP_PC, DIR_SALTO[1:0]};
`endif

   // Acks only count in PEDIR; DESCARTE acks are dropped.
   assign acepta      = (estado_q == PEDIR) && IMEM_ACK;
   assign libre       = !valid_q || !STALL;
   assign skid_load   = !RST && !SALTO && acepta && !libre;
   assign skid_unload = !RST && !SALTO && libre && skid_full;

   buffer_salto_instr u_skid (
      .clk_i    (CLK),
      .rst_i    (RST),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .flush_i  (SALTO),
      .data_i   (IMEM_DATA),
      .pc_i     (addr_q),
      .data_o   (skid_data),
      .pc_o     (skid_pc),
      .full_o   (skid_full)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         estado_q <= ARRANQUE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         req_q    <= 1'b0;
         instr_q  <= NOP_INSTR;
         ipc_q    <= RESET_PC;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= SALTO && mis_d;
         if (SALTO) begin
            pc_q    <= tgt_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            // A request still in flight must complete before the new address goes out.
            if ((estado_q == PEDIR || estado_q == DESCARTE) && !IMEM_ACK) begin
               estado_q <= DESCARTE;
            end else begin
               estado_q <= PEDIR;
               addr_q   <= tgt_d;
            end
         end else begin
            if (libre) begin
               if (skid_full) begin
                  instr_q <= skid_data;
                  ipc_q   <= skid_pc;
                  valid_q <= 1'b1;
               end else if (acepta) begin
                  instr_q <= IMEM_DATA;
                  ipc_q   <= addr_q;
                  valid_q <= 1'b1;
               end else begin
                  valid_q <= 1'b0;
               end
            end

            case (estado_q)
               ARRANQUE: begin
                  estado_q <= PEDIR;
                  req_q    <= 1'b1;
                  addr_q   <= pc_q;
               end
               PEDIR: begin
                  if (IMEM_ACK) begin
                     pc_q     <= PC4;
                     addr_q   <= PC4;
                     req_q    <= !skid_load;
                     estado_q <= skid_load ? ESPERA : PEDIR;
                  end
               end
               ESPERA: begin
                  if (!STALL) begin
                     estado_q <= PEDIR;
                     req_q    <= 1'b1;
                  end
               end
               DESCARTE: begin
                  if (IMEM_ACK) begin
                     estado_q <= PEDIR;
                     addr_q   <= pc_q;
                  end
               end
               default: estado_q <= ARRANQUE;
            endcase
         end
      end
   end

   assign PC          = pc_q;
   assign IMEM_REQ    = req_q;
   assign IMEM_ADDR   = addr_q;
   assign INSTR       = instr_q;
   assign INSTR_PC    = ipc_q;
   assign INSTR_VALID = valid_q;
   assign ERR_ALIGN   = err_q;

endmodule

// File: tb/tb_etapa_busqueda_pc.sv
// Bench for etapa_busqueda_pc: directed literal checks plus a randomized run
// compared each cycle against a program-order delivery model.
module tb_etapa_busqueda_pc;

   logic        CLK;
   logic        RST;
   logic [31:0] PC, PC4;
   logic        SALTO;
   logic [31:0] DIR_SALTO;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_ACK;
   logic [31:0] IMEM_DATA;
   logic [31:0] INSTR, INSTR_PC;
   logic        INSTR_VALID;
   logic        STALL;
   logic        ERR_ALIGN;

   logic [31:0] pc2, pc4_2, addr2, instr2, ipc2, data2;
   logic        req2, valid2, err2;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_deliv = 0;
   int unsigned ack_pct = 100;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] eff_tgt(input logic [31:0] d);
`ifdef PC_ALIGN_CHECK_EN
      return (d % 4 != 0) ? 32'h0000_0100 : d;
`else
      return d - (d % 4);
`endif
   endfunction

   function automatic logic mis_of(input logic [31:0] d);
`ifdef PC_ALIGN_CHECK_EN
      return (d % 4 != 0);
`else
      return (d == 32'hFFFF_FFFF) && (d != 32'hFFFF_FFFF);
`endif
   endfunction

   assign PC4       = PC + 32'd4;
   assign IMEM_DATA = mem_word(IMEM_ADDR);
   assign pc4_2     = pc2 + 32'd4;
   assign data2     = mem_word(addr2);

   etapa_busqueda_pc dut (
      .CLK(CLK), .RST(RST), .PC(PC), .PC4(PC4), .SALTO(SALTO), .DIR_SALTO(DIR_SALTO),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
      .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID), .STALL(STALL),
      .ERR_ALIGN(ERR_ALIGN)
   );

   etapa_busqueda_pc #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .CLK(CLK), .RST(RST), .PC(pc2), .PC4(pc4_2), .SALTO(1'b0), .DIR_SALTO(32'h0),
      .IMEM_REQ(req2), .IMEM_ADDR(addr2), .IMEM_ACK(req2), .IMEM_DATA(data2),
      .INSTR(instr2), .INSTR_PC(ipc2), .INSTR_VALID(valid2), .STALL(1'b0),
      .ERR_ALIGN(err2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stl, input logic slt, input logic [31:0] dir);
      @(posedge CLK);
      #1;
      RST       = rst;
      STALL     = stl;
      SALTO     = slt;
      DIR_SALTO = dir;
      IMEM_ACK  = (IMEM_REQ === 1'b1) && ($urandom_range(0, 99) < ack_pct);
      @(negedge CLK);
   endtask

   // Behavioural model: instructions must reach decode in program order,
   // each once, from the reset PC or the latest redirect target.
   logic        mdl_on = 1'b0;
   logic [31:0] exp_next, drop_tgt;
   logic        drop_act, drop_chk;
   logic        p_valid, p_stall, p_salto, p_req, p_ack, p_mis;
   logic [31:0] p_addr, p_instr, p_ipc, p_tgt;

   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         mdl_on   = 1'b1;
         exp_next = 32'h0;
         drop_act = 1'b0; drop_chk = 1'b0; drop_tgt = 32'h0;
         p_valid = 1'b0; p_stall = 1'b0; p_salto = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_mis = 1'b0;
         p_addr = 32'h0; p_instr = 32'h0; p_ipc = 32'h0; p_tgt = 32'h0;
      end else if (mdl_on) begin
         chk1("err_align", ERR_ALIGN, p_salto && p_mis);
         if (p_salto) begin
            chk1("valid_after_salto", INSTR_VALID, 1'b0);
            chk("pc_after_salto", PC, p_tgt);
            if (!(p_req && !p_ack)) begin
               chk("addr_after_salto", IMEM_ADDR, p_tgt);
               chk1("req_after_salto", IMEM_REQ, 1'b1);
            end
         end
         if (drop_chk) begin
            chk("addr_after_drop", IMEM_ADDR, drop_tgt);
            chk1("req_after_drop", IMEM_REQ, 1'b1);
         end
         if (p_req && !p_ack) begin
            chk1("req_stable", IMEM_REQ, 1'b1);
            chk("addr_stable", IMEM_ADDR, p_addr);
         end
         if (p_valid && p_stall && !p_salto) begin
            chk1("hold_valid", INSTR_VALID, 1'b1);
            chk("hold_instr", INSTR, p_instr);
            chk("hold_pc", INSTR_PC, p_ipc);
         end
         if (INSTR_VALID === 1'b1 && !(p_valid && p_stall)) begin
            chk("deliv_pc", INSTR_PC, exp_next);
            chk("deliv_instr", INSTR, mem_word(exp_next));
            exp_next = exp_next + 32'd4;
            n_deliv++;
         end

         drop_chk = 1'b0;
         if (SALTO) begin
            exp_next = eff_tgt(DIR_SALTO);
            drop_tgt = eff_tgt(DIR_SALTO);
            drop_act = IMEM_REQ && !IMEM_ACK;
         end else if (drop_act && IMEM_ACK) begin
            drop_act = 1'b0;
            drop_chk = 1'b1;
         end
         p_valid = INSTR_VALID; p_stall = STALL; p_salto = SALTO;
         p_req = IMEM_REQ; p_ack = IMEM_ACK; p_mis = SALTO && mis_of(DIR_SALTO);
         p_addr = IMEM_ADDR; p_instr = INSTR; p_ipc = INSTR_PC; p_tgt = eff_tgt(DIR_SALTO);
      end
   end

   logic [31:0] exp_mis;
   logic        exp_err;
   logic        stl, slt;
   logic [31:0] dir;

   initial begin
      RST = 1'b1; STALL = 1'b0; SALTO = 1'b0; DIR_SALTO = 32'h0; IMEM_ACK = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      exp_mis = 32'h0000_0100; exp_err = 1'b1;
`else
      exp_mis = 32'h0000_0200; exp_err = 1'b0;
`endif
      repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0);

      // Cycle 0 after reset release
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_addr", IMEM_ADDR, 32'h0);
      chk("rst_instr_pc", INSTR_PC, 32'h0);
      chk("rst_instr", INSTR, 32'h0000_0013);
      chk1("rst_req", IMEM_REQ, 1'b0);
      chk1("rst_valid", INSTR_VALID, 1'b0);
      chk1("rst_err", ERR_ALIGN, 1'b0);
      chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
      chk1("wrap_rst_req", req2, 1'b0);

      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("first_req", IMEM_REQ, 1'b1);
      chk("first_addr", IMEM_ADDR, 32'h0);
      chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);

      for (int k = 2; k <= 7; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         chk1("run_valid", INSTR_VALID, 1'b1);
         chk("run_ipc", INSTR_PC, 32'(4 * (k - 2)));
         if (k == 2) begin
            chk("wrap_second_addr", addr2, 32'h0);
            chk("wrap_pc", pc2, 32'h0);
            chk1("wrap_valid", valid2, 1'b1);
            chk("wrap_ipc0", ipc2, 32'hFFFF_FFFC);
         end
         if (k == 3) begin
            chk("wrap_ipc1", ipc2, 32'h0);
            chk("wrap_instr1", instr2, mem_word(32'h0));
            chk1("wrap_err", err2, 1'b0);
         end
      end

      // Three stall cycles with continuous ack
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      for (int k = 9; k <= 10; k++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0);
         chk1("stall_req", IMEM_REQ, 1'b0);
         chk("stall_hold_ipc", INSTR_PC, 32'd24);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("release_req", IMEM_REQ, 1'b0);
      chk("release_ipc", INSTR_PC, 32'd24);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("skid_ipc", INSTR_PC, 32'd28);
      chk1("resume_req", IMEM_REQ, 1'b1);
      chk("resume_addr", IMEM_ADDR, 32'd32);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("after_skid_ipc", INSTR_PC, 32'd32);

      // Redirect coincident with ack
      drive(1'b0, 1'b0, 1'b1, 32'h300);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("coinc_addr", IMEM_ADDR, 32'h300);
      chk1("coinc_valid", INSTR_VALID, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("coinc_ipc", INSTR_PC, 32'h300);

      // Reset while an ack is in flight
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      ack_pct = 0;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("midrst_req", IMEM_REQ, 1'b0);
      chk1("midrst_valid", INSTR_VALID, 1'b0);

      // Redirect while request pending, ack delayed two cycles
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h200);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("drop_req", IMEM_REQ, 1'b1);
      chk("drop_addr_held", IMEM_ADDR, 32'h0);
      chk("drop_pc", PC, 32'h200);
      ack_pct = 100;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("drop_new_addr", IMEM_ADDR, 32'h200);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("drop_valid", INSTR_VALID, 1'b1);
      chk("drop_ipc", INSTR_PC, 32'h200);

      // Misaligned redirect
      drive(1'b0, 1'b0, 1'b1, 32'h202);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("mis_pc", PC, exp_mis);
      chk("mis_addr", IMEM_ADDR, exp_mis);
      chk1("mis_err", ERR_ALIGN, exp_err);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("mis_err_clear", ERR_ALIGN, 1'b0);
      chk("mis_ipc", INSTR_PC, exp_mis);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ack_pct = 65;
         stl = ($urandom_range(0, 99) < 35);
         slt = ($urandom_range(0, 99) < 5);
         dir = 32'h0000_1000 + 32'($urandom_range(0, 255) << 2);
         if ($urandom_range(0, 7) == 0) dir = dir + 32'd2;
         if ($urandom_range(0, 15) == 0) dir = 32'hFFFF_FFF8;
         drive(1'b0, stl, slt, dir);
      end
      repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("progress", n_deliv > 300, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
